// File: rtl/processing_unit_pkg.sv
// rtl/processing_unit_pkg.sv - shared opcode and bus-select codes for the RISC_SPM datapath
package processing_unit_pkg;

  localparam int WORD_SIZE = 8;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_RD  = 4'b0101;
  localparam logic [3:0] OP_WR  = 4'b0110;
  localparam logic [3:0] OP_BR  = 4'b0111;
  localparam logic [3:0] OP_BRZ = 4'b1000;

  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

endpackage

// File: rtl/processing_unit_alu.sv
// rtl/processing_unit_alu.sv - combinational ALU; data_1 is Y, data_2 is Bus_1
module alu
  import processing_unit_pkg::*;
#(
  parameter int WORD_SIZE = processing_unit_pkg::WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] data_1,
  input  logic [WORD_SIZE-1:0] data_2,
  input  logic [3:0]           opcode,
  output logic [WORD_SIZE-1:0] alu_out
);

  always_comb begin
    alu_out = '0;
    case (opcode)
      OP_ADD:  alu_out = data_1 + data_2;
      OP_SUB:  alu_out = data_2 - data_1;
      OP_AND:  alu_out = data_1 & data_2;
      OP_NOT:  alu_out = ~data_2;
      default: alu_out = '0;
    endcase
  end

endmodule

// File: rtl/processing_unit.sv
// rtl/processing_unit.sv - RISC_SPM datapath: R0-R3, PC, IR, address, Y, Z, bus muxes and ALU
module processing_unit
  import processing_unit_pkg::*;
#(
  parameter int WORD_SIZE = processing_unit_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Load_R0,
  input  logic                 Load_R1,
  input  logic                 Load_R2,
  input  logic                 Load_R3,
  input  logic                 Load_PC,
  input  logic                 Inc_PC,
  input  logic                 Load_IR,
  input  logic                 Load_Add_R,
  input  logic                 Load_Reg_Y,
  input  logic                 Load_Reg_Z,
  input  logic [2:0]           Sel_Bus_1_Mux,
  input  logic [1:0]           Sel_Bus_2_Mux,
  input  logic [WORD_SIZE-1:0] mem_word,
  output logic [WORD_SIZE-1:0] instruction,
  output logic                 Zflag,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] Bus_1
);

  logic [WORD_SIZE-1:0] r0, r1, r2, r3, pc, ir, add_r, reg_y;
  logic                 reg_z;
  logic [WORD_SIZE-1:0] bus_2;
  logic [WORD_SIZE-1:0] alu_out;

  always_comb begin
    Bus_1 = '0;
    case (Sel_Bus_1_Mux)
      SEL1_R0: Bus_1 = r0;
      SEL1_R1: Bus_1 = r1;
      SEL1_R2: Bus_1 = r2;
      SEL1_R3: Bus_1 = r3;
      SEL1_PC: Bus_1 = pc;
      default: Bus_1 = '0;
    endcase
  end

  always_comb begin
    bus_2 = '0;
    case (Sel_Bus_2_Mux)
      SEL2_ALU:  bus_2 = alu_out;
      SEL2_BUS1: bus_2 = Bus_1;
      SEL2_MEM:  bus_2 = mem_word;
      default:   bus_2 = '0;
    endcase
  end

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .data_1  (reg_y),
    .data_2  (Bus_1),
    .opcode  (ir[WORD_SIZE-1 -: 4]),
    .alu_out (alu_out)
  );

  // All loads sample the same pre-edge bus_2, so PC feeding Bus_1 back into PC sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0    <= '0;
      r1    <= '0;
      r2    <= '0;
      r3    <= '0;
      pc    <= '0;
      ir    <= '0;
      add_r <= '0;
      reg_y <= '0;
      reg_z <= 1'b0;
    end else begin
      if (Load_R0)    r0    <= bus_2;
      if (Load_R1)    r1    <= bus_2;
      if (Load_R2)    r2    <= bus_2;
      if (Load_R3)    r3    <= bus_2;
      if (Load_IR)    ir    <= bus_2;
      if (Load_Add_R) add_r <= bus_2;
      if (Load_Reg_Y) reg_y <= bus_2;
      if (Load_Reg_Z) reg_z <= (alu_out == '0);
      if (Load_PC)
        pc <= bus_2;
      else if (Inc_PC)
        pc <= pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    end
  end

  assign instruction = ir;
  assign address     = add_r;
  assign Zflag       = reg_z;

endmodule
